atom_ps2_keyboard: RTL and testbench
====================================

Name: atom_ps2_keyboard

Overview:
- PS/2 keyboard front end that emulates the Atom 10x6 key matrix.
- Consumes the 8255 Port A row select (bits 3:0).
- Produces Port B column/SHIFT/CTRL bits and the Port C REPT bit.
- Decodes PS/2 set-2 make/break frames into a registered key-state matrix, read back combinationally by row.

Parameters:
TIMEOUT_CYCLES, 20000, clk cycles without a PS/2 falling edge before a partial frame is discarded
ROWS, 10, number of matrix rows implemented (rows 0..ROWS-1)

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
ps2_clk  input  1  raw PS/2 clock from connector (asynchronous)
ps2_data  input  1  raw PS/2 data from connector (asynchronous)
row  input  4  row select from 8255 Port A[3:0]
col_n  output  6  column bits to Port B[5:0], low = key pressed
ctrl_n  output  1  to Port B[6], low while CTRL held
shift_n  output  1  to Port B[7], low while either SHIFT held
rept_n  output  1  to Port C[6], low while REPT held
break_n  output  1  low while BREAK key held (see Optional Feature)
code_stb  output  1  one-cycle strobe per accepted scan byte (debug)
code  output  8  last accepted scan byte (debug)

Behaviour:
- ps2_clk and ps2_data pass through 2-FF synchronisers. A falling edge is synced clk 1->0, detected one cycle after.
- Receiver FSM states:
  - IDLE: on falling edge with data=0 (start bit) -> DATA, bitcnt=0. Falling edge with data=1 is ignored.
  - DATA: sample 8 bits LSB first on falling edges; after the 8th bit -> PARITY.
  - PARITY: sample parity bit -> STOP.
  - STOP: sample stop bit -> IDLE. Byte accepted only if data bits + parity have odd weight and stop=1. Otherwise dropped silently and prefix flags cleared.
- Timeout: in any state other than IDLE, a counter counts clk cycles since the last falling edge. Reaching TIMEOUT_CYCLES forces IDLE, drops the partial byte, and leaves the prefix flags unchanged.
- Accepted byte: code_stb=1 for exactly one cycle, the cycle after the stop-bit edge is detected; code is updated in the same cycle.
- Prefix handling:
  - 0xE0 sets ext; 0xF0 sets brk. Both flags persist until the next non-prefix byte, which consumes and clears both.
- Key event (non-prefix byte): pressed = !brk.
  - Normal codes are looked up in the Atom keymap (full table per Atom Technical Manual key matrix).
  - Fixed entries: 0x29 SPACE -> row 9 col 0; 0x5A RETURN -> row 6 col 1; 0x1C A -> row 3 col 5; 0x12/0x59 SHIFT -> shift_l/shift_r; 0x14 CTRL -> ctrl; 0x11 ALT -> rept.
  - Extended codes: E0 14 -> ctrl; E0 5A -> RETURN; E0 12 and E0 59 (fake shifts) ignored; all other extended codes ignored.
  - Unmapped codes are ignored.
- Matrix update: the matrix bit/flag is written in the same cycle as code_stb. It is visible on outputs from the next cycle.
- Break for a key not held: no change. Repeated make (typematic) for a held key: no change.
- col_n = ~matrix[row] combinationally. row >= ROWS gives col_n = 6'h3F. Multiple keys held in one row drive multiple low bits.
- shift_n = ~(shift_l | shift_r). ctrl_n and rept_n are inverted flags.
- Reset (asynchronous, any time incl. mid-frame):
  - FSM to IDLE; matrix, flags, ext and brk cleared.
  - col_n=6'h3F, shift_n=ctrl_n=rept_n=break_n=1, code_stb=0, code=8'h00.

Optional Feature:
- Macro: ATOM_KBD_BREAK_EN.
- Defined: scan 0x07 (F12) make drives break_n low; F12 break releases it. Used by the top level as CPU reset request.
- Undefined: break_n tied to 1; 0x07 treated as unmapped.

Test Plan:
- Reset mid-frame (after 4 data bits of 0x1C) -> col_n=3F for all rows, no code_stb; a subsequent full 0x1C frame is accepted normally.
- Send 1C with row=3 -> col_n=6'h1F one cycle after code_stb, code=1C; send F0 1C -> col_n=6'h3F.
- Send 12, then 59, then F0 12 -> shift_n low after 12, still low after F0 12, high only after F0 59.
- Frame 0x29 with bad parity -> no code_stb, row 9 col_n stays 3F. Then a partial frame idle for TIMEOUT_CYCLES+1 -> FSM back to IDLE; next valid 0x29 frame sets row 9 col_n=6'h3E.
- Send 29 and 5A; sweep row 0..15 -> only row 9 = 3E and row 6 = 3D; rows 10..15 = 3F. E0 12 -> shift_n stays 1. E0 5A -> row 6 = 3D.
- With ATOM_KBD_BREAK_EN: 07 -> break_n=0; F0 07 -> break_n=1. Without the macro: break_n stays 1 and code_stb still pulses with code=07.

Source files
------------

// File: rtl/atom_ps2_keyboard.sv
// atom_ps2_keyboard: PS/2 set-2 keyboard front end emulating the Acorn Atom
// 10x6 key matrix. The 8255 Port A row select reads back column, SHIFT, CTRL
// and REPT bits combinationally from a registered key-state matrix.
// Optional build macro ATOM_KBD_BREAK_EN: F12 (scan 0x07) drives break_n as a
// CPU reset request. When the macro is undefined, break_n is tied high and
// 0x07 is treated as unmapped.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for a start bit (data low on falling edge)
// S_DATA  | shifting in 8 data bits, LSB first
// S_PARITY| sampling the odd-parity bit
// S_STOP  | sampling the stop bit, then accept or drop the byte
module atom_ps2_keyboard #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int ROWS           = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] row,
  output logic [5:0] col_n,
  output logic       ctrl_n,
  output logic       shift_n,
  output logic       rept_n,
  output logic       break_n,
  output logic       code_stb,
  output logic [7:0] code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t         state, state_nxt;
  logic [1:0]     clk_sync, data_sync;
  logic           clk_dly;
  logic           fall;
  logic           data_s;
  logic [2:0]     bitcnt;
  logic [7:0]     shreg;
  logic           par;
  logic [TW-1:0]  tmr;
  logic           timeout;
  logic           byte_ok;
  logic           byte_bad;

  logic           ext, brk;
  logic           shift_l, shift_r, ctrl, rept;
  logic [5:0]     matrix [ROWS];
  logic           pressed;
  logic           key_hit;
  logic [3:0]     key_row;
  logic [2:0]     key_col;
  logic           sel_shl, sel_shr, sel_ctrl, sel_rept;
`ifdef ATOM_KBD_BREAK_EN
  logic           sel_brk;
  logic           break_key;
`endif

  // Atom key matrix lookup: {hit, row[3:0], col[2:0]} for a plain scan code.
  // Arrow keys are extended codes and are not reachable here.
  function automatic logic [7:0] keymap(input logic [7:0] sc);
    logic [7:0] km;
    km = 8'h00;
    case (sc)
      8'h26: km = {1'b1, 4'd0, 3'd1}; // 3
      8'h4E: km = {1'b1, 4'd0, 3'd2}; // -
      8'h34: km = {1'b1, 4'd0, 3'd3}; // G
      8'h15: km = {1'b1, 4'd0, 3'd4}; // Q
      8'h76: km = {1'b1, 4'd0, 3'd5}; // ESC
      8'h1E: km = {1'b1, 4'd1, 3'd1}; // 2
      8'h41: km = {1'b1, 4'd1, 3'd2}; // ,
      8'h2B: km = {1'b1, 4'd1, 3'd3}; // F
      8'h4D: km = {1'b1, 4'd1, 3'd4}; // P
      8'h1A: km = {1'b1, 4'd1, 3'd5}; // Z
      8'h16: km = {1'b1, 4'd2, 3'd1}; // 1
      8'h4C: km = {1'b1, 4'd2, 3'd2}; // ;
      8'h24: km = {1'b1, 4'd2, 3'd3}; // E
      8'h44: km = {1'b1, 4'd2, 3'd4}; // O
      8'h35: km = {1'b1, 4'd2, 3'd5}; // Y
      8'h45: km = {1'b1, 4'd3, 3'd1}; // 0
      8'h52: km = {1'b1, 4'd3, 3'd2}; // : on quote key
      8'h23: km = {1'b1, 4'd3, 3'd3}; // D
      8'h31: km = {1'b1, 4'd3, 3'd4}; // N
      8'h1C: km = {1'b1, 4'd3, 3'd5}; // A
      8'h58: km = {1'b1, 4'd4, 3'd0}; // LOCK on caps lock
      8'h66: km = {1'b1, 4'd4, 3'd1}; // DELETE on backspace
      8'h46: km = {1'b1, 4'd4, 3'd2}; // 9
      8'h21: km = {1'b1, 4'd4, 3'd3}; // C
      8'h3A: km = {1'b1, 4'd4, 3'd4}; // M
      8'h1D: km = {1'b1, 4'd4, 3'd5}; // W
      8'h55: km = {1'b1, 4'd5, 3'd0}; // ^ on = key
      8'h0D: km = {1'b1, 4'd5, 3'd1}; // COPY on tab
      8'h3E: km = {1'b1, 4'd5, 3'd2}; // 8
      8'h32: km = {1'b1, 4'd5, 3'd3}; // B
      8'h4B: km = {1'b1, 4'd5, 3'd4}; // L
      8'h2A: km = {1'b1, 4'd5, 3'd5}; // V
      8'h5B: km = {1'b1, 4'd6, 3'd0}; // ]
      8'h5A: km = {1'b1, 4'd6, 3'd1}; // RETURN
      8'h3D: km = {1'b1, 4'd6, 3'd2}; // 7
      8'h22: km = {1'b1, 4'd6, 3'd3}; // X
      8'h42: km = {1'b1, 4'd6, 3'd4}; // K
      8'h3C: km = {1'b1, 4'd6, 3'd5}; // U
      8'h5D: km = {1'b1, 4'd7, 3'd0}; // backslash
      8'h36: km = {1'b1, 4'd7, 3'd2}; // 6
      8'h0E: km = {1'b1, 4'd7, 3'd3}; // @ on backtick
      8'h3B: km = {1'b1, 4'd7, 3'd4}; // J
      8'h2C: km = {1'b1, 4'd7, 3'd5}; // T
      8'h54: km = {1'b1, 4'd8, 3'd0}; // [
      8'h2E: km = {1'b1, 4'd8, 3'd2}; // 5
      8'h4A: km = {1'b1, 4'd8, 3'd3}; // /
      8'h43: km = {1'b1, 4'd8, 3'd4}; // I
      8'h1B: km = {1'b1, 4'd8, 3'd5}; // S
      8'h29: km = {1'b1, 4'd9, 3'd0}; // SPACE
      8'h25: km = {1'b1, 4'd9, 3'd2}; // 4
      8'h49: km = {1'b1, 4'd9, 3'd3}; // .
      8'h33: km = {1'b1, 4'd9, 3'd4}; // H
      8'h2D: km = {1'b1, 4'd9, 3'd5}; // R
      default: km = 8'h00;
    endcase
    return km;
  endfunction

  // Two-flop synchronisers; idle-high reset avoids a false edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_dly   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_dly   <= clk_sync[1];
    end
  end

  assign fall   = clk_dly & ~clk_sync[1];
  assign data_s = data_sync[1];

  // Receiver state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Receiver next-state logic; a stalled frame times out back to idle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall && !data_s) state_nxt = S_DATA;
      S_DATA:   if (timeout) state_nxt = S_IDLE;
                else if (fall && bitcnt == 3'd7) state_nxt = S_PARITY;
      S_PARITY: if (timeout) state_nxt = S_IDLE;
                else if (fall) state_nxt = S_STOP;
      S_STOP:   if (timeout || fall) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Receiver outputs: timeout and end-of-frame accept/drop decisions
  always_comb begin
    timeout  = (state != S_IDLE) && !fall && (tmr == '0);
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    if (state == S_STOP && fall) begin
      byte_ok  = (^{par, shreg}) & data_s;
      byte_bad = ~byte_ok;
    end
  end

  // Frame datapath: shift register, bit counter, parity and inactivity timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= 8'h00;
      bitcnt <= 3'd0;
      par    <= 1'b0;
      tmr    <= TW'(TIMEOUT_CYCLES);
    end else begin
      if (state == S_IDLE && fall) bitcnt <= 3'd0;
      if (state == S_DATA && fall) begin
        shreg  <= {data_s, shreg[7:1]};
        bitcnt <= bitcnt + 3'd1;
      end
      if (state == S_PARITY && fall) par <= data_s;
      if (fall || state == S_IDLE) tmr <= TW'(TIMEOUT_CYCLES);
      else if (tmr != '0)          tmr <= tmr - TW'(1);
    end
  end

  // Accepted byte register and one-cycle strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_stb <= 1'b0;
      code     <= 8'h00;
    end else begin
      code_stb <= byte_ok;
      if (byte_ok) code <= shreg;
    end
  end

  // Decode the accepted byte into a matrix position or modifier flag
  always_comb begin
    key_hit  = 1'b0;
    key_row  = 4'd0;
    key_col  = 3'd0;
    sel_shl  = 1'b0;
    sel_shr  = 1'b0;
    sel_ctrl = 1'b0;
    sel_rept = 1'b0;
`ifdef ATOM_KBD_BREAK_EN
    sel_brk  = 1'b0;
`endif
    if (ext) begin
      case (code)
        8'h14: sel_ctrl = 1'b1;
        8'h5A: begin key_hit = 1'b1; key_row = 4'd6; key_col = 3'd1; end
        default: ;
      endcase
    end else begin
      case (code)
        8'h12: sel_shl  = 1'b1;
        8'h59: sel_shr  = 1'b1;
        8'h14: sel_ctrl = 1'b1;
        8'h11: sel_rept = 1'b1;
`ifdef ATOM_KBD_BREAK_EN
        8'h07: sel_brk  = 1'b1;
`endif
        default: {key_hit, key_row, key_col} = keymap(code);
      endcase
    end
  end

  assign pressed = ~brk;

  // Prefix tracking and key-state update, one cycle behind the accepted byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext     <= 1'b0;
      brk     <= 1'b0;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
      ctrl    <= 1'b0;
      rept    <= 1'b0;
`ifdef ATOM_KBD_BREAK_EN
      break_key <= 1'b0;
`endif
      for (int r = 0; r < ROWS; r++) matrix[r] <= 6'h00;
    end else if (byte_bad) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (code_stb) begin
      if (code == 8'hE0) ext <= 1'b1;
      else if (code == 8'hF0) brk <= 1'b1;
      else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (sel_shl)  shift_l <= pressed;
        if (sel_shr)  shift_r <= pressed;
        if (sel_ctrl) ctrl    <= pressed;
        if (sel_rept) rept    <= pressed;
`ifdef ATOM_KBD_BREAK_EN
        if (sel_brk)  break_key <= pressed;
`endif
        for (int r = 0; r < ROWS; r++)
          if (key_hit && key_row == 4'(r)) matrix[r][key_col] <= pressed;
      end
    end
  end

  // Row readback; unimplemented rows read as no key pressed
  always_comb begin
    col_n = 6'h3F;
    for (int r = 0; r < ROWS; r++)
      if (row == 4'(r)) col_n = ~matrix[r];
  end

  assign shift_n = ~(shift_l | shift_r);
  assign ctrl_n  = ~ctrl;
  assign rept_n  = ~rept;
`ifdef ATOM_KBD_BREAK_EN
  assign break_n = ~break_key;
`else
  assign break_n = 1'b1;
`endif

endmodule

// File: tb/tb_atom_ps2_keyboard.sv
// Directed testbench for atom_ps2_keyboard. Honours ATOM_KBD_BREAK_EN.
module tb_atom_ps2_keyboard;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] row = 4'd0;
  logic [5:0] col_n;
  logic       ctrl_n, shift_n, rept_n, break_n, code_stb;
  logic [7:0] code;

  int         n_chk = 0;
  int         n_fail = 0;
  int         stb_cnt = 0;
  int         stb_base;
  logic [7:0] last_code = 8'h00;
  logic [5:0] col_after = 6'h00;
  logic       stb_pend = 1'b0;

  atom_ps2_keyboard #(.TIMEOUT_CYCLES(TO), .ROWS(10)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .row(row), .col_n(col_n), .ctrl_n(ctrl_n), .shift_n(shift_n),
    .rept_n(rept_n), .break_n(break_n), .code_stb(code_stb), .code(code)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts strobes, keeps last code and col_n one cycle later
  always @(negedge clk) begin
    if (code_stb) begin
      stb_cnt   = stb_cnt + 1;
      last_code = code;
      stb_pend  = 1'b1;
    end else if (stb_pend) begin
      col_after = col_n;
      stb_pend  = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive the first nbits of a frame: start, 8 data LSB first, parity, stop
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (4) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (8) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(posedge clk);
    end
    ps2_data = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < 16; r++) begin
      row = 4'(r);
      #1 chk("rst_col", 32'(col_n), 32'h3F);
    end
    chk("rst_shift", 32'(shift_n), 32'd1);
    chk("rst_ctrl", 32'(ctrl_n), 32'd1);
    chk("rst_rept", 32'(rept_n), 32'd1);
    chk("rst_break", 32'(break_n), 32'd1);
    chk("rst_stb", 32'(code_stb), 32'd0);
    chk("rst_code", 32'(code), 32'h00);
    @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Reset mid-frame after four data bits of 0x1C
    stb_base = stb_cnt;
    send_bits(8'h1C, 1'b0, 5);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_nostb", 32'(stb_cnt - stb_base), 32'd0);
    row = 4'd3;
    #1 chk("midrst_row3", 32'(col_n), 32'h3F);

    // A press and release
    stb_base = stb_cnt;
    send(8'h1C);
    chk("a_stb", 32'(stb_cnt - stb_base), 32'd1);
    chk("a_code", 32'(last_code), 32'h1C);
    chk("a_col_next", 32'(col_after), 32'h1F);
    send(8'h1C);
    chk("a_typematic", 32'(col_n), 32'h1F);
    send(8'hF0); send(8'h1C);
    chk("a_rel", 32'(col_n), 32'h3F);
    send(8'hF0); send(8'h1C);
    chk("a_rel_again", 32'(col_n), 32'h3F);

    // Both shifts
    send(8'h12);
    chk("shl", 32'(shift_n), 32'd0);
    send(8'h59);
    chk("shr", 32'(shift_n), 32'd0);
    send(8'hF0); send(8'h12);
    chk("shl_rel", 32'(shift_n), 32'd0);
    send(8'hF0); send(8'h59);
    chk("shr_rel", 32'(shift_n), 32'd1);

    // Bad parity, then a stalled partial frame, then a good SPACE
    row = 4'd9;
    stb_base = stb_cnt;
    send_bits(8'h29, 1'b1, 11);
    chk("badpar_nostb", 32'(stb_cnt - stb_base), 32'd0);
    chk("badpar_row9", 32'(col_n), 32'h3F);
    send_bits(8'h29, 1'b0, 4);
    repeat (TO + 20) @(posedge clk);
    stb_base = stb_cnt;
    send(8'h29);
    chk("to_stb", 32'(stb_cnt - stb_base), 32'd1);
    chk("to_code", 32'(last_code), 32'h29);
    chk("space_row9", 32'(col_n), 32'h3E);

    // Row sweep with SPACE and RETURN held
    send(8'h5A);
    for (int r = 0; r < 16; r++) begin
      logic [5:0] e;
      e = (r == 9) ? 6'h3E : (r == 6) ? 6'h3D : 6'h3F;
      row = 4'(r);
      #1 chk("sweep", 32'(col_n), 32'(e));
    end
    send(8'h2D);
    row = 4'd9;
    #1 chk("row9_two", 32'(col_n), 32'h1E);

    // Extended codes
    send(8'hE0); send(8'h12);
    chk("fake_shift", 32'(shift_n), 32'd1);
    send(8'h12);
    chk("shift_after_ext", 32'(shift_n), 32'd0);
    send(8'hF0); send(8'h12);
    row = 4'd6;
    send(8'hF0); send(8'h5A);
    chk("ret_rel", 32'(col_n), 32'h3F);
    send(8'hE0); send(8'h5A);
    chk("ext_ret", 32'(col_n), 32'h3D);
    send(8'hE0); send(8'hF0); send(8'h5A);
    chk("ext_ret_rel", 32'(col_n), 32'h3F);
    send(8'hE0); send(8'h14);
    chk("ext_ctrl", 32'(ctrl_n), 32'd0);
    send(8'hF0); send(8'h14);
    chk("ctrl_rel", 32'(ctrl_n), 32'd1);
    send(8'h11);
    chk("rept", 32'(rept_n), 32'd0);
    send(8'hF0); send(8'h11);
    chk("rept_rel", 32'(rept_n), 32'd1);

    // F12 / BREAK
    stb_base = stb_cnt;
    send(8'h07);
    chk("f12_stb", 32'(stb_cnt - stb_base), 32'd1);
    chk("f12_code", 32'(last_code), 32'h07);
`ifdef ATOM_KBD_BREAK_EN
    chk("break_on", 32'(break_n), 32'd0);
`else
    chk("break_tied", 32'(break_n), 32'd1);
`endif
    send(8'hF0); send(8'h07);
    chk("break_off", 32'(break_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
